mul_scheduler: RTL and testbench

//   Multi-channel, time-shared fixed-point multiplier; successor to the single-operand multiplier wrapper.
//   N_CH requesters share one iterative radix-4 datapath through a round-robin arbiter.

---
 rtl/mul_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_mul_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_scheduler.sv
// mul_scheduler: N_CH requesters share one iterative radix-4 fixed-point
// multiplier through a round-robin arbiter. Results go out with the
// originating channel tag and a saturation flag.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both 1. in_ready is combinational, is only
// asserted in IDLE, and is one-hot or zero. out_valid stays high and
// out_y/out_ch/out_sat stay stable until the edge where out_ready is 1.
// A requester may drop in_valid without a transfer.
module mul_scheduler #(
   parameter int C_WIDTH     = 16,
   parameter int FIXED_POINT = 8,
   parameter int N_CH        = 4,
   parameter int SIGNED      = 1,
   parameter int ROUND       = 1,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                      ctl_clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           in_valid,
   output logic [N_CH-1:0]           in_ready,
   input  logic [N_CH*C_WIDTH-1:0]   in_a,
   input  logic [N_CH*C_WIDTH-1:0]   in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [C_WIDTH-1:0]        out_y,
   output logic [CH_W-1:0]           out_ch,
   output logic                      out_sat,
   output logic [1:0]                o_dbg_state
);

   localparam int W     = C_WIDTH;
   localparam int PW    = 2 * C_WIDTH;
   localparam int CNT_W = $clog2(C_WIDTH / 2 + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_WIDTH / 2);
   localparam logic [PW:0]      ONE      = (PW + 1)'(1);
   localparam int               RND_SH   = (FIXED_POINT > 0) ? FIXED_POINT - 1 : 0;
   localparam logic [PW:0]      RND      = (ROUND != 0 && FIXED_POINT > 0) ? (ONE << RND_SH) : '0;
   localparam logic [PW:0]      LIM_POS  = (ONE << (W - 1)) - ONE;
   localparam logic [PW:0]      LIM_NEG  = ONE << (W - 1);
   localparam logic [PW:0]      LIM_U    = (ONE << W) - ONE;

   // MUL spends its first cycle forming 3|a| so the digit adds never see a
   // 3-input adder; the remaining C_WIDTH/2 cycles each retire one digit.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   r_ch;
   logic              r_sign;
   logic [CNT_W-1:0]  r_cnt;
   logic [PW-1:0]     r_ma;
   logic [PW-1:0]     r_ma3;
   logic [W-1:0]      r_mb;
   logic [PW-1:0]     r_acc;
   logic              r_out_valid;
   logic [W-1:0]      r_out_y;
   logic [CH_W-1:0]   r_out_ch;
   logic              r_out_sat;

   logic [W-1:0]      w_a_ch [N_CH];
   logic [W-1:0]      w_b_ch [N_CH];
   logic [CH_W-1:0]   w_idx;
   logic [CH_W-1:0]   w_grant;
   logic              w_grant_found;
   logic [CH_W-1:0]   w_rr_nxt;
   logic [N_CH-1:0]   w_in_ready;
   logic [W-1:0]      w_a_sel;
   logic [W-1:0]      w_b_sel;
   logic [W-1:0]      w_mag_a;
   logic [W-1:0]      w_mag_b;
   logic              w_sign;
   logic [PW-1:0]     w_pp;
   logic [PW:0]       w_sum;
   logic [PW:0]       w_m;
   logic [PW:0]       w_lim;
   logic [W-1:0]      w_mag;
   logic              w_sat;
   logic [W-1:0]      w_y;

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign w_a_ch[k] = in_a[k*C_WIDTH +: C_WIDTH];
      assign w_b_ch[k] = in_b[k*C_WIDTH +: C_WIDTH];
   end

   // Round-robin search: first requesting channel at or above r_rr_ptr, wrapping.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant       = '0;
      w_idx         = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_idx = CH_W'((int'(r_rr_ptr) + i) % N_CH);
         if (!w_grant_found && in_valid[w_idx]) begin
            w_grant_found = 1'b1;
            w_grant       = w_idx;
         end
      end
      w_rr_nxt = (w_grant == CH_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
   end

   // Operand selection and sign/magnitude split for the granted channel.
   always_comb begin
      w_a_sel = w_a_ch[w_grant];
      w_b_sel = w_b_ch[w_grant];
      w_sign  = 1'b0;
      w_mag_a = w_a_sel;
      w_mag_b = w_b_sel;
      if (SIGNED != 0) begin
         w_sign  = w_a_sel[W-1] ^ w_b_sel[W-1];
         w_mag_a = w_a_sel[W-1] ? -w_a_sel : w_a_sel;
         w_mag_b = w_b_sel[W-1] ? -w_b_sel : w_b_sel;
      end
   end

   // Radix-4 partial product for the current two LSBs of |b|.
   always_comb begin
      w_pp = '0;
      case (r_mb[1:0])
         2'd0:    w_pp = '0;
         2'd1:    w_pp = r_ma;
         2'd2:    w_pp = r_ma << 1;
         default: w_pp = r_ma3;
      endcase
   end

   // Round, shift down to the output scale, clamp and re-apply the sign.
   always_comb begin
      w_sum = {1'b0, r_acc} + RND;
      w_m   = w_sum >> FIXED_POINT;
      if (SIGNED != 0) begin
         w_lim = r_sign ? LIM_NEG : LIM_POS;
      end else begin
         w_lim = LIM_U;
      end
      w_sat = 1'b0;
      w_mag = w_m[W-1:0];
      if (w_m > w_lim) begin
         w_sat = 1'b1;
         w_mag = w_lim[W-1:0];
      end
      w_y = (SIGNED != 0 && r_sign) ? -w_mag : w_mag;
   end

   // FSM state register.
   always_ff @(posedge ctl_clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and grant decode.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_found) begin
               w_in_ready[w_grant] = 1'b1;
               w_state_nxt         = S_MUL;
            end
         end
         S_MUL: begin
            if (r_cnt == CNT_LAST) w_state_nxt = S_NORM;
         end
         S_NORM: w_state_nxt = S_OUT;
         S_OUT: begin
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath, arbiter pointer and output registers.
   always_ff @(posedge ctl_clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr    <= '0;
         r_ch        <= '0;
         r_sign      <= 1'b0;
         r_cnt       <= '0;
         r_ma        <= '0;
         r_ma3       <= '0;
         r_mb        <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
         r_out_ch    <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_found) begin
                  r_ma     <= PW'(w_mag_a);
                  r_mb     <= w_mag_b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_sign   <= w_sign;
                  r_ch     <= w_grant;
                  r_rr_ptr <= w_rr_nxt;
               end
            end
            S_MUL: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == '0) begin
                  r_ma3 <= r_ma + (r_ma << 1);
               end else begin
                  r_acc <= r_acc + w_pp;
                  r_ma  <= r_ma << 2;
                  r_ma3 <= r_ma3 << 2;
                  r_mb  <= r_mb >> 2;
               end
            end
            S_NORM: begin
               r_out_y     <= w_y;
               r_out_ch    <= r_ch;
               r_out_sat   <= w_sat;
               r_out_valid <= 1'b1;
            end
            default: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // in_ready is held low while reset is asserted even though IDLE is forced.
   assign in_ready    = reset ? w_in_ready : '0;
   assign out_valid   = r_out_valid;
   assign out_y       = r_out_y;
   assign out_ch      = r_out_ch;
   assign out_sat     = r_out_sat;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: three instances (default, ROUND=0, SIGNED=0)
// share stimulus; a vector table covers arithmetic cases, hand sequences
// cover arbitration, backpressure and reset mid-operation.
module tb_mul_scheduler;

   typedef struct {
      int          ch;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y_r;
      logic        s_r;
      logic [15:0] y_t;
      logic        s_t;
      logic [15:0] y_u;
      logic        s_u;
   } vec_t;

   logic        ctl_clk = 1'b0;
   logic        reset;
   logic [3:0]  in_valid;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_ready;
   logic        mon_en = 1'b0;

   logic [3:0]  in_ready, nr_in_ready, us_in_ready;
   logic        out_valid, nr_out_valid, us_out_valid;
   logic [15:0] out_y, nr_out_y, us_out_y;
   logic [1:0]  out_ch, nr_out_ch, us_out_ch;
   logic        out_sat, nr_out_sat, us_out_sat;
   logic [1:0]  dbg_state, nr_dbg_state, us_dbg_state;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [17:0] exp_q[$];
   vec_t        vecs[15];

   mul_scheduler dut (
      .ctl_clk(ctl_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_ch(out_ch), .out_sat(out_sat), .o_dbg_state(dbg_state)
   );

   mul_scheduler #(.ROUND(0)) dut_nr (
      .ctl_clk(ctl_clk), .reset(reset), .in_valid(in_valid), .in_ready(nr_in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(nr_out_valid), .out_ready(out_ready),
      .out_y(nr_out_y), .out_ch(nr_out_ch), .out_sat(nr_out_sat), .o_dbg_state(nr_dbg_state)
   );

   mul_scheduler #(.SIGNED(0)) dut_us (
      .ctl_clk(ctl_clk), .reset(reset), .in_valid(in_valid), .in_ready(us_in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(us_out_valid), .out_ready(out_ready),
      .out_y(us_out_y), .out_ch(us_out_ch), .out_sat(us_out_sat), .o_dbg_state(us_dbg_state)
   );

   // Clock.
   always #5 ctl_clk = ~ctl_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Grant must never be multi-hot.
   always @(negedge ctl_clk) begin
      if (mon_en) check("in_ready onehot0", 32'($onehot0(in_ready)), 32'd1);
   end

   task automatic do_reset();
      @(negedge ctl_clk);
      reset = 1'b0;
      @(negedge ctl_clk);
      reset = 1'b1;
   endtask

   // Raise one request, wait for its grant, cross the accept edge, then scramble inputs.
   task automatic accept(input int ch, input logic [15:0] a, input logic [15:0] b);
      int n;
      in_valid = '0;
      in_valid[ch] = 1'b1;
      in_a[ch*16 +: 16] = a;
      in_b[ch*16 +: 16] = b;
      #1;
      n = 0;
      while (in_ready[ch] !== 1'b1 && n < 50) begin
         @(negedge ctl_clk);
         #1;
         n++;
      end
      if (in_ready[ch] !== 1'b1) check("grant timeout", 32'(in_ready), 32'(1 << ch));
      @(posedge ctl_clk);
      #1;
      in_valid = '0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
   endtask

   // Count edges from the accept edge until out_valid is seen.
   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge ctl_clk);
         #1;
         lat++;
      end
      if (out_valid !== 1'b1) check("out_valid timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin
      int lat;
      int got;
      int cyc;
      logic [17:0] e;

      vecs[0]  = '{0, 16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300, 1'b0, 16'h0300, 1'b0};
      vecs[1]  = '{1, 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 16'hFD00, 1'b0, 16'hFFFF, 1'b1};
      vecs[2]  = '{2, 16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b0};
      vecs[3]  = '{3, 16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
      vecs[4]  = '{0, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b0};
      vecs[5]  = '{1, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hFE00, 1'b0};
      vecs[6]  = '{2, 16'h8100, 16'h0200, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
      vecs[7]  = '{3, 16'hFF00, 16'h0200, 16'hFE00, 1'b0, 16'hFE00, 1'b0, 16'hFFFF, 1'b1};
      vecs[8]  = '{0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
      vecs[9]  = '{1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[10] = '{2, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[11] = '{3, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0, 16'h0100, 1'b0};
      vecs[12] = '{0, 16'hFFFD, 16'h0080, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0, 16'h7FFF, 1'b0};
      vecs[13] = '{1, 16'h0123, 16'h0456, 16'h04EE, 1'b0, 16'h04ED, 1'b0, 16'h04EE, 1'b0};
      vecs[14] = '{2, 16'h0123, 16'hFBAA, 16'hFB12, 1'b0, 16'hFB13, 1'b0, 16'hFFFF, 1'b1};

      // Reset state, with every channel requesting.
      reset     = 1'b0;
      in_valid  = 4'hF;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge ctl_clk);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_y", 32'(out_y), 32'd0);
      check("reset out_ch", 32'(out_ch), 32'd0);
      check("reset out_sat", 32'(out_sat), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);
      in_valid = '0;
      @(negedge ctl_clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge ctl_clk);

      // Arithmetic vector table.
      for (int i = 0; i < 15; i++) begin
         accept(vecs[i].ch, vecs[i].a, vecs[i].b);
         wait_out(lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd10);
         check($sformatf("vec%0d ch", i), 32'(out_ch), 32'(vecs[i].ch));
         check($sformatf("vec%0d y_round", i), 32'(out_y), 32'(vecs[i].y_r));
         check($sformatf("vec%0d sat_round", i), 32'(out_sat), 32'(vecs[i].s_r));
         check($sformatf("vec%0d valid_trunc", i), 32'(nr_out_valid), 32'd1);
         check($sformatf("vec%0d y_trunc", i), 32'(nr_out_y), 32'(vecs[i].y_t));
         check($sformatf("vec%0d sat_trunc", i), 32'(nr_out_sat), 32'(vecs[i].s_t));
         check($sformatf("vec%0d valid_uns", i), 32'(us_out_valid), 32'd1);
         check($sformatf("vec%0d y_uns", i), 32'(us_out_y), 32'(vecs[i].y_u));
         check($sformatf("vec%0d sat_uns", i), 32'(us_out_sat), 32'(vecs[i].s_u));
         @(posedge ctl_clk);
         #1;
         check($sformatf("vec%0d valid_drop", i), 32'(out_valid), 32'd0);
      end

      // Round-robin with all channels requesting continuously.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         in_a[k*16 +: 16] = 16'((k + 1) << 8);
         in_b[k*16 +: 16] = 16'h0100;
      end
      for (int k = 0; k < 6; k++) exp_q.push_back({2'(k % 4), 16'(((k % 4) + 1) << 8)});
      in_valid = 4'hF;
      got = 0;
      cyc = 0;
      while (got < 6 && cyc < 200) begin
         @(negedge ctl_clk);
         cyc++;
         if (out_valid) begin
            e = exp_q.pop_front();
            check($sformatf("arb result%0d ch_y", got), 32'({out_ch, out_y}), 32'(e));
            got++;
         end
      end
      check("arb result count", 32'(got), 32'd6);
      in_valid = '0;
      do_reset();

      // Backpressure: result held, no grants while the output is stalled.
      out_ready = 1'b0;
      accept(2, 16'h0180, 16'h0200);
      in_valid = 4'hF;
      wait_out(lat);
      for (int c = 0; c < 20; c++) begin
         @(negedge ctl_clk);
         check($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d y", c), 32'(out_y), 32'h0300);
         check($sformatf("bp%0d ch", c), 32'(out_ch), 32'd2);
         check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge ctl_clk);
      @(negedge ctl_clk);
      check("bp next grant", 32'(in_ready), 32'h8);
      in_valid = '0;
      #1;
      check("bp dropped request", 32'(in_ready), 32'd0);
      @(negedge ctl_clk);

      // Reset during MUL discards the transaction and rewinds the pointer.
      accept(2, 16'h0100, 16'h0300);
      repeat (3) @(posedge ctl_clk);
      @(negedge ctl_clk);
      reset = 1'b0;
      #1;
      check("midrst out_y", 32'(out_y), 32'd0);
      check("midrst state", 32'(dbg_state), 32'd0);
      @(negedge ctl_clk);
      reset = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge ctl_clk);
         check($sformatf("midrst%0d no valid", c), 32'(out_valid), 32'd0);
      end
      in_valid = 4'hF;
      #1;
      check("midrst grant ch0", 32'(in_ready), 32'h1);
      accept(0, 16'h0100, 16'h0200);
      wait_out(lat);
      check("midrst ch", 32'(out_ch), 32'd0);
      check("midrst y", 32'(out_y), 32'h0200);
      @(posedge ctl_clk);
      #1;
      check("midrst valid drop", 32'(out_valid), 32'd0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
